// File: rtl/alu_pkg.sv
// Shared types for the serial ALU datapath: opcodes and the
// sequencer state encoding.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } ser_state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice; SUB is a + ~b + 1, so b is inverted here and the
// caller seeds the carry with 1.
module serial_alu_slice
    import alu_pkg::*;
(
    input  logic    at,
    input  logic    bt,
    input  logic    cin,
    input  alu_op_t op,
    output logic    res,
    output logic    cout
);

    logic w_bt;

    assign w_bt = bt ^ (op == OP_SUB);

    always_comb begin
        res  = 1'b0;
        cout = 1'b0;
        unique case (op)
            OP_AND: res = at & bt;
            OP_OR:  res = at | bt;
            OP_ADD, OP_SUB: begin
                res  = at ^ w_bt ^ cin;
                cout = (at & w_bt) | (at & cin) | (w_bt & cin);
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: operands shift LSB-first through one slice with a
// registered carry; the result is reassembled and flagged with a pulse.
module bit_serial_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             carry_out,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_t       r_state;
    alu_op_t          r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sh_r;
    logic             r_carry;
    logic             w_res;
    logic             w_cout;

    serial_alu_slice u_slice (
        .at   (r_sh_a[0]),
        .bt   (r_sh_b[0]),
        .cin  (r_carry),
        .op   (r_op),
        .res  (w_res),
        .cout (w_cout)
    );

    assign ready = (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= OP_AND;
            r_cnt        <= '0;
            r_sh_a       <= '0;
            r_sh_b       <= '0;
            r_sh_r       <= '0;
            r_carry      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            carry_out    <= 1'b0;
            zero         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_op    <= alu_op_t'(op);
                        r_carry <= (op == 2'b11);
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_sh_r  <= {w_res, r_sh_r[WIDTH-1:1]};
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    result       <= r_sh_r;
                    carry_out    <= r_carry;
                    zero         <= (r_sh_r == '0);
                    result_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Scoreboard bench for bit_serial_alu: directed ops, reset abort,
// busy-start drop and a 200-op back-to-back random run.
module tb_bit_serial_alu;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         result_valid;
    logic         carry_out;
    logic         zero;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb[$];

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .ready        (ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result       (result),
        .result_valid (result_valid),
        .carry_out    (carry_out),
        .zero         (zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(logic [1:0] o, logic [W-1:0] x,
                                   logic [W-1:0] y);
        exp_t   m;
        logic [W:0] s;
        m.c = 1'b0;
        case (o)
            2'b00: m.r = x & y;
            2'b01: m.r = x | y;
            2'b10: begin
                s = {1'b0, x} + {1'b0, y};
                m.r = s[W-1:0];
                m.c = s[W];
            end
            default: begin
                m.r = x - y;
                m.c = (x >= y);
            end
        endcase
        m.z = (m.r == '0);
        return m;
    endfunction

    task automatic launch(logic [1:0] o, logic [W-1:0] x, logic [W-1:0] y);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges from the one following the start-accept edge.
    task automatic wait_valid(output bit got, output int lat);
        lat = 1;
        while (!result_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        got = result_valid;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 1'b1 || result_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0",
                     ready, result_valid);
        end
        total++;
        if (result !== 8'h00 || carry_out !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: res=%h c=%b z=%b want 00 0 0",
                     result, carry_out, zero);
        end
    endtask

    task automatic test_add;
        bit   got;
        int   lat;
        exp_t e;
        sb.push_back('{8'h00, 1'b1, 1'b1});
        launch(2'b10, 8'hFF, 8'h01);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL add_valid: no pulse within %0d cycles", lat);
        end
        total++;
        if (lat !== W + 2) begin
            bad++;
            $display("FAIL add_latency: got %0d want %0d", lat, W + 2);
        end
        total++;
        if (result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL add_ripple: res=%h c=%b z=%b want %h %b %b",
                     result, carry_out, zero, e.r, e.c, e.z);
        end
        @(negedge clk);
        total++;
        if (result_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_pulse_width: valid=%b want 0", result_valid);
        end
        total++;
        if (result !== e.r) begin
            bad++;
            $display("FAIL add_hold: res=%h want %h", result, e.r);
        end
    endtask

    task automatic test_sub;
        bit   got;
        int   lat;
        exp_t e;
        sb.push_back('{8'h30, 1'b1, 1'b0});
        launch(2'b11, 8'h50, 8'h20);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL sub_noborrow: v=%b res=%h c=%b z=%b want %h %b %b",
                     got, result, carry_out, zero, e.r, e.c, e.z);
        end
        sb.push_back('{8'hD0, 1'b0, 1'b0});
        launch(2'b11, 8'h20, 8'h50);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL sub_borrow: v=%b res=%h c=%b z=%b want %h %b %b",
                     got, result, carry_out, zero, e.r, e.c, e.z);
        end
    endtask

    task automatic test_logic;
        bit   got;
        int   lat;
        exp_t e;
        sb.push_back('{8'h24, 1'b0, 1'b0});
        launch(2'b00, 8'hA5, 8'h3C);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL and_op: v=%b res=%h c=%b z=%b want %h %b %b",
                     got, result, carry_out, zero, e.r, e.c, e.z);
        end
        sb.push_back('{8'hBD, 1'b0, 1'b0});
        launch(2'b01, 8'hA5, 8'h3C);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL or_op: v=%b res=%h c=%b z=%b want %h %b %b",
                     got, result, carry_out, zero, e.r, e.c, e.z);
        end
    endtask

    task automatic test_busy;
        bit   got;
        int   lat;
        int   extra = 0;
        exp_t e;
        sb.push_back('{8'h46, 1'b0, 1'b0});
        launch(2'b10, 8'h12, 8'h34);
        @(negedge clk);
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ready: ready=%b want 0", ready);
        end
        op = 2'b10;
        a = 8'h01;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'hEE;
        b = 8'hEE;
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c) begin
            bad++;
            $display("FAIL busy_result: v=%b res=%h c=%b want %h %b",
                     got, result, carry_out, e.r, e.c);
        end
        repeat (25) begin
            @(negedge clk);
            if (result_valid) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("FAIL busy_drop: extra pulses=%0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        bit got;
        int lat;
        exp_t e;
        launch(2'b10, 8'h0F, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ready !== 1'b1 || result !== 8'h00 || result_valid !== 1'b0 ||
            carry_out !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: rdy=%b res=%h v=%b c=%b z=%b want 1 00 0 0 0",
                     ready, result, result_valid, carry_out, zero);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (result_valid) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL rst_abort: pulses=%0d want 0", seen);
        end
        sb.push_back('{8'h10, 1'b0, 1'b0});
        launch(2'b10, 8'h0F, 8'h01);
        wait_valid(got, lat);
        e = sb.pop_front();
        total++;
        if (!got || result !== e.r || carry_out !== e.c || zero !== e.z) begin
            bad++;
            $display("FAIL rst_recover: v=%b res=%h c=%b z=%b want %h %b %b",
                     got, result, carry_out, zero, e.r, e.c, e.z);
        end
    endtask

    task automatic test_back_to_back;
        int   launched = 0;
        int   popped = 0;
        int   bud = 0;
        int   last = -1;
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        exp_t e;
        @(negedge clk);
        o = 2'($urandom_range(0, 3));
        x = W'($urandom);
        y = W'($urandom);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(model(o, x, y));
        launched = 1;
        while (popped < 200 && bud < 2600) begin
            @(negedge clk);
            bud++;
            if (result_valid) begin
                e = sb.pop_front();
                popped++;
                total++;
                if (result !== e.r || carry_out !== e.c || zero !== e.z) begin
                    bad++;
                    $display("FAIL b2b_data #%0d: res=%h c=%b z=%b want %h %b %b",
                             popped, result, carry_out, zero, e.r, e.c, e.z);
                end
                if (last >= 0) begin
                    total++;
                    if (cyc - last !== W + 2) begin
                        bad++;
                        $display("FAIL b2b_spacing #%0d: got %0d want %0d",
                                 popped, cyc - last, W + 2);
                    end
                end
                last = cyc;
            end
            if (ready) begin
                if (launched < 200) begin
                    o = 2'($urandom_range(0, 3));
                    x = W'($urandom);
                    y = W'($urandom);
                    op = o;
                    a = x;
                    b = y;
                    sb.push_back(model(o, x, y));
                    launched++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        total++;
        if (popped !== 200) begin
            bad++;
            $display("FAIL b2b_count: results=%0d want 200", popped);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_logic;
        test_busy;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
Name: bit_serial_alu

Overview:
- Bit-serial counterpart of the 8-bit parallel ALU. It accepts two parallel operands and an opcode through a start/ready handshake.
- Each operand is shifted LSB-first through a single 1-bit ALU slice, with a registered carry between bits.
- The result is reassembled in parallel, and a one-cycle valid pulse is raised when it is complete.
- It sits between the register file and the writeback path of the bit-serial CPU datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, never overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request; accepted only on a cycle where ready=1.
- ready  output  1  high in IDLE; the block can accept start.
- op  input  2  opcode, sampled with start: 00 AND, 01 OR, 10 ADD, 11 SUB (a-b).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- result  output  WIDTH  registered result; holds its value until the next completion.
- result_valid  output  1  one-cycle pulse when result, carry_out and zero update.
- carry_out  output  1  final carry; 0 for AND/OR; for SUB, 1 means no borrow (a>=b unsigned).
- zero  output  1  high when result==0; updates with result_valid.

Behaviour:
- Reset values: ready=1, result=0, result_valid=0, carry_out=0, zero=0; state=IDLE; counter, shift registers and carry flop cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch a into sh_a, b into sh_b and op into op_q.
  - Set the carry flop to 1 if op=SUB, otherwise 0. Set counter=0. Go to SHIFT.
- SHIFT:
  - ready=0.
  - Each cycle, the slice combines sh_a[0], b_eff and the carry flop, where b_eff = sh_b[0] XOR (op_q==SUB).
  - AND/OR produce the logical bit and the carry flop is held at 0. ADD/SUB produce sum = a^b_eff^c and cout = majority(a, b_eff, c).
  - Result bit shifts into the MSB of sh_r (right shift). sh_a and sh_b shift right. The carry flop takes cout. Counter increments.
  - When counter==WIDTH-1, go to DONE after that cycle's bit is processed. Exactly WIDTH cycles are spent in SHIFT.
- DONE:
  - Copy sh_r to result and the carry flop to carry_out. zero = (sh_r==0).
  - Assert result_valid for exactly this cycle; ready=0. Return to IDLE next cycle.
- Latency: start sampled at edge N gives result_valid high during the cycle after edge N+WIDTH+1, i.e. WIDTH+2 cycles from start to valid. The next start can be accepted on the cycle following the valid pulse.
- start while ready=0: ignored. No queuing, and in-flight operands are unaffected.
- start held high continuously: a new operation launches each time IDLE is reached, with back-to-back throughput of one result per WIDTH+2 cycles.
- Arithmetic: unsigned and modulo 2^WIDTH, with wrap-around on ADD overflow and SUB underflow. No signed overflow flag.
- Reset mid-operation: the operation is aborted. Outputs return to their reset values and no result_valid is produced.
- Operand inputs are don't-care outside the start-accept cycle.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_t enum (OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11);
  - ser_state_t enum (S_IDLE, S_SHIFT, S_DONE).
- One sub-module: serial_alu_slice.
  - Combinational 1-bit ALU with inputs at, bt, cin, op and outputs res, cout.
  - It performs the SUB inversion internally.
  - It is reused by future serial shifter/compare blocks.

Test Plan:
- Reset/idle: assert rst mid-SHIFT (op=ADD, a=8'h0F, b=8'h01) -> ready=1, result=0, no result_valid pulse, a later op completes normally.
- ADD with carry ripple: op=10, a=8'hFF, b=8'h01 -> after 10 cycles result=8'h00, carry_out=1, zero=1, single-cycle valid.
- SUB no borrow/borrow: a=8'h50, b=8'h20 -> result=8'h30, carry_out=1; then a=8'h20, b=8'h50 -> result=8'hD0, carry_out=0, zero=0.
- Logic ops: AND a=8'hA5, b=8'h3C -> result=8'h24, carry_out=0; OR with the same operands -> result=8'hBD.
- Start during busy: pulse start with a=8'h01, b=8'h01 while ready=0 on a running ADD 8'h12+8'h34 -> result=8'h46, exactly one valid pulse, second request dropped.
- Back-to-back: start held high with random op/a/b for 200 operations -> every result matches the reference model, and valid pulses are spaced exactly WIDTH+2 cycles apart.
